// File: rtl/user_guard_pkg.sv
// Shared types for the user-core NMI guard: FSM states, error causes and
// the byte-strobe legality check.
package user_guard_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } guard_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_BLOCKED = 2'b01,
        CAUSE_TIMEOUT = 2'b10,
        CAUSE_WSTRB   = 2'b11
    } err_cause_e;

    // Only naturally aligned byte, halfword and word strobes reach the SoC.
    function automatic logic wstrb_legal(input logic [3:0] wstrb);
        logic ok;
        case (wstrb)
            4'b0000, 4'b0001, 4'b0010, 4'b0100,
            4'b1000, 4'b0011, 4'b1100, 4'b1111: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/nmi_if.sv
// Native memory interface bundle between the user core, the guard and the SoC.
interface nmi_if;
    logic        valid;
    logic        ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;

    modport master (
        output valid, addr, wdata, wstrb,
        input  ready, rdata
    );

    modport slave (
        input  valid, addr, wdata, wstrb,
        output ready, rdata
    );
endinterface

// File: rtl/user_guard_wdog.sv
// Downstream wait timer: counts forwarded cycles and flags the last one
// allowed before the guard aborts; holds at that value instead of wrapping.
module user_guard_wdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != CNT_LAST)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = (cnt == CNT_LAST);

endmodule

// File: rtl/user_nmi_guard.sv
// Guard between a user core NMI master and the SoC: blocks a protected
// address window, rejects odd byte strobes and aborts stalled transfers.
//
// state | meaning
// IDLE  | waiting for core.valid; request is classified and captured here
// FWD   | registered request presented on soc, wait timer running
// RESP  | one cycle of core.ready with the captured soc.rdata
// ERR   | one cycle of core.ready with ERR_RDATA, no soc transfer
module user_nmi_guard
    import user_guard_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF,
    parameter logic [31:0] BLK_BASE       = 32'hF000_0000,
    parameter logic [31:0] BLK_MASK       = 32'hF000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    nmi_if.slave        core,
    nmi_if.master       soc,
    input  logic        err_clr_i,
    output logic        err_irq_o,
    output logic [1:0]  err_cause_o,
    output logic [31:0] err_addr_o
);

    guard_state_e state;

    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        soc_valid_q;
    logic        core_ready_q;
    logic [31:0] core_rdata_q;

    logic        irq_q;
    err_cause_e  cause_q;
    logic [31:0] err_addr_q;

    logic        req_blocked;
    logic        req_wstrb_ok;
    logic        wdog_clr;
    logic        wdog_en;
    logic        wdog_expired;

    logic        new_err;
    err_cause_e  new_cause;
    logic [31:0] new_err_addr;

    assign req_blocked  = ((core.addr & BLK_MASK) == BLK_BASE);
    assign req_wstrb_ok = wstrb_legal(core.wstrb);

    assign wdog_clr = (state == ST_IDLE) && core.valid && !req_blocked && req_wstrb_ok;
    assign wdog_en  = (state == ST_FWD) && !soc.ready;

    user_guard_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr     (wdog_clr),
        .en      (wdog_en),
        .expired (wdog_expired)
    );

    // A blocked address outranks a bad strobe; a soc.ready on the final
    // wait cycle still completes normally.
    always_comb begin
        new_err      = 1'b0;
        new_cause    = CAUSE_NONE;
        new_err_addr = req_addr;
        if ((state == ST_IDLE) && core.valid) begin
            new_err_addr = core.addr;
            if (req_blocked) begin
                new_err   = 1'b1;
                new_cause = CAUSE_BLOCKED;
            end else if (!req_wstrb_ok) begin
                new_err   = 1'b1;
                new_cause = CAUSE_WSTRB;
            end
        end else if ((state == ST_FWD) && !soc.ready && wdog_expired) begin
            new_err   = 1'b1;
            new_cause = CAUSE_TIMEOUT;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state        <= ST_IDLE;
            soc_valid_q  <= 1'b0;
            core_ready_q <= 1'b0;
            core_rdata_q <= '0;
            req_addr     <= '0;
            req_wdata    <= '0;
            req_wstrb    <= '0;
        end else begin
            core_ready_q <= 1'b0;
            core_rdata_q <= '0;
            case (state)
                ST_IDLE: begin
                    if (core.valid) begin
                        req_addr  <= core.addr;
                        req_wdata <= core.wdata;
                        req_wstrb <= core.wstrb;
                        if (new_err) begin
                            state        <= ST_ERR;
                            core_ready_q <= 1'b1;
                            core_rdata_q <= ERR_RDATA;
                        end else begin
                            state       <= ST_FWD;
                            soc_valid_q <= 1'b1;
                        end
                    end
                end
                ST_FWD: begin
                    if (soc.ready) begin
                        state        <= ST_RESP;
                        soc_valid_q  <= 1'b0;
                        core_ready_q <= 1'b1;
                        core_rdata_q <= soc.rdata;
                    end else if (wdog_expired) begin
                        state        <= ST_ERR;
                        soc_valid_q  <= 1'b0;
                        core_ready_q <= 1'b1;
                        core_rdata_q <= ERR_RDATA;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The first error since the last clear is kept; a clear coinciding
    // with a new error lets the new one load.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            irq_q      <= 1'b0;
            cause_q    <= CAUSE_NONE;
            err_addr_q <= '0;
        end else if (new_err) begin
            irq_q <= 1'b1;
            if (!irq_q || err_clr_i) begin
                cause_q    <= new_cause;
                err_addr_q <= new_err_addr;
            end
        end else if (err_clr_i) begin
            irq_q      <= 1'b0;
            cause_q    <= CAUSE_NONE;
            err_addr_q <= '0;
        end
    end

    assign soc.valid  = soc_valid_q;
    assign soc.addr   = req_addr;
    assign soc.wdata  = req_wdata;
    assign soc.wstrb  = req_wstrb;

    assign core.ready = core_ready_q;
    assign core.rdata = core_rdata_q;

    assign err_irq_o   = irq_q;
    assign err_cause_o = cause_q;
    assign err_addr_o  = err_addr_q;

endmodule
